// File: rtl/core_step_ctrl_if.sv
// Core-side bus of the picoMIPS run/step controller: enable, data in/out, address, result.
// The breakpoint address member exists only when STEP_CTRL_BKPT_EN is defined.
`timescale 1ns/1ps
interface core_step_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
);
  logic          core_en_o;
  logic [DW-1:0] core_data_o;
  logic [DW-1:0] core_data_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] result_o;
  logic          result_valid_o;
`ifdef STEP_CTRL_BKPT_EN
  logic [AW-1:0] bkpt_addr_i;

  modport slave (
    output core_en_o, core_data_o, result_o, result_valid_o,
    input  core_data_i, core_addr_i, bkpt_addr_i
  );
  modport master (
    input  core_en_o, core_data_o, result_o, result_valid_o,
    output core_data_i, core_addr_i, bkpt_addr_i
  );
`else
  modport slave (
    output core_en_o, core_data_o, result_o, result_valid_o,
    input  core_data_i, core_addr_i
  );
  modport master (
    input  core_en_o, core_data_o, result_o, result_valid_o,
    output core_data_i, core_addr_i
  );
`endif
endinterface

// File: rtl/core_step_ctrl.sv
// Run/step sequencer for the picoMIPS core: key conditioning, clock-enable FSM,
// input-data latch and result capture. Optional breakpoint halt: STEP_CTRL_BKPT_EN.
`timescale 1ns/1ps
module core_step_ctrl #(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 2,
  parameter int unsigned DIV_W       = 22,
  parameter int unsigned DB_W        = 16,
  parameter int unsigned RESULT_ADDR = 3
) (
  input  logic          clk_i,
  input  logic          n_rst_i,
  input  logic          run_mode_i,
  input  logic          step_key_n_i,
  input  logic          load_key_n_i,
  input  logic [DW-1:0] sw_data_i,
  output logic [1:0]    state_o,
  core_step_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      run_sync_q, run_sync_d;
  logic [1:0]      step_sync_q, step_sync_d;
  logic [1:0]      load_sync_q, load_sync_d;
  logic [DB_W-1:0] step_cnt_q, step_cnt_d;
  logic [DB_W-1:0] load_cnt_q, load_cnt_d;
  logic            step_db_q, step_db_d;
  logic            load_db_q, load_db_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic            core_en_q, core_en_d;
  logic            en_dly_q, en_dly_d;
  logic [DW-1:0]   core_data_q, core_data_d;
  logic [DW-1:0]   result_q, result_d;
  logic            valid_q, valid_d;
  logic            bkpt_q, bkpt_d;
  logic            run_c, step_evt_c, load_evt_c, block_c, bkpt_hit_c;

  // Synchronisers and debounce: a pending level change must persist until the counter saturates
  always_comb begin
    run_sync_d  = {run_sync_q[0],  run_mode_i};
    step_sync_d = {step_sync_q[0], step_key_n_i};
    load_sync_d = {load_sync_q[0], load_key_n_i};

    step_cnt_d = step_cnt_q;
    step_db_d  = step_db_q;
    if (step_sync_q[1] == step_db_q) begin
      step_cnt_d = '0;
    end else if (step_cnt_q == '1) begin
      step_db_d  = step_sync_q[1];
      step_cnt_d = '0;
    end else begin
      step_cnt_d = step_cnt_q + DB_W'(1);
    end

    load_cnt_d = load_cnt_q;
    load_db_d  = load_db_q;
    if (load_sync_q[1] == load_db_q) begin
      load_cnt_d = '0;
    end else if (load_cnt_q == '1) begin
      load_db_d  = load_sync_q[1];
      load_cnt_d = '0;
    end else begin
      load_cnt_d = load_cnt_q + DB_W'(1);
    end
  end

  assign run_c      = run_sync_q[1];
  assign step_evt_c = step_db_q & ~step_db_d;
  assign load_evt_c = load_db_q & ~load_db_d;

`ifdef STEP_CTRL_BKPT_EN
  assign block_c    = bkpt_q;
  assign bkpt_hit_c = en_dly_q && (bus.core_addr_i == bus.bkpt_addr_i);
`else
  assign block_c    = 1'b0;
  assign bkpt_hit_c = 1'b0;
`endif

  // Sequencer: core_en_d is the registered enable for the following cycle
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    core_en_d = 1'b0;
    bkpt_d    = bkpt_q;
    if (!run_c) bkpt_d = 1'b0;

    case (state_q)
      ST_HALT: begin
        presc_d = '0;
        if (run_c && !block_c) begin
          state_d = ST_RUN;
        end else if (step_evt_c) begin
          state_d   = ST_STEP;
          core_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = (run_c && !block_c) ? ST_RUN : ST_HALT;
      end
      ST_RUN: begin
        if (!run_c) begin
          state_d = ST_HALT;
          presc_d = '0;
        end else if (bkpt_hit_c) begin
          state_d = ST_HALT;
          presc_d = '0;
          bkpt_d  = 1'b1;
        end else begin
          presc_d   = presc_q + DIV_W'(1);
          core_en_d = (presc_q == '1);
        end
      end
      default: begin
        state_d = ST_HALT;
        presc_d = '0;
      end
    endcase
  end

  // Input latch and result capture; a load invalidates any result taken for older data
  always_comb begin
    en_dly_d    = core_en_q;
    core_data_d = load_evt_c ? sw_data_i : core_data_q;
    result_d    = result_q;
    valid_d     = valid_q;
    if (en_dly_q && (bus.core_addr_i == AW'(RESULT_ADDR))) begin
      result_d = bus.core_data_i;
      valid_d  = 1'b1;
    end
    if (load_evt_c) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= ST_HALT;
      run_sync_q  <= 2'b00;
      step_sync_q <= 2'b11;
      load_sync_q <= 2'b11;
      step_cnt_q  <= '0;
      load_cnt_q  <= '0;
      step_db_q   <= 1'b1;
      load_db_q   <= 1'b1;
      presc_q     <= '0;
      core_en_q   <= 1'b0;
      en_dly_q    <= 1'b0;
      core_data_q <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      bkpt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_sync_q  <= run_sync_d;
      step_sync_q <= step_sync_d;
      load_sync_q <= load_sync_d;
      step_cnt_q  <= step_cnt_d;
      load_cnt_q  <= load_cnt_d;
      step_db_q   <= step_db_d;
      load_db_q   <= load_db_d;
      presc_q     <= presc_d;
      core_en_q   <= core_en_d;
      en_dly_q    <= en_dly_d;
      core_data_q <= core_data_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      bkpt_q      <= bkpt_d;
    end
  end

  assign state_o            = state_q;
  assign bus.core_en_o      = core_en_q;
  assign bus.core_data_o    = core_data_q;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = valid_q;

endmodule

// File: tb/tb_core_step_ctrl.sv
// Self-checking bench for core_step_ctrl with DB_W=4, DIV_W=3, RESULT_ADDR=3.
`timescale 1ns/1ps
module tb_core_step_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          run_mode;
  logic          step_n;
  logic          load_n;
  logic [DW-1:0] sw;
  logic [1:0]    state;

  core_step_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  core_step_ctrl #(
    .DW(DW), .AW(AW), .DIV_W(3), .DB_W(4), .RESULT_ADDR(3)
  ) dut (
    .clk_i        (clk),
    .n_rst_i      (n_rst),
    .run_mode_i   (run_mode),
    .step_key_n_i (step_n),
    .load_key_n_i (load_n),
    .sw_data_i    (sw),
    .state_o      (state),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] prev_data = '0;
  int en_count = 0;
  int data_changes = 0;

  typedef struct {
    logic [DW-1:0] sw;
    logic [DW-1:0] exp_data;
  } load_vec_t;
  load_vec_t lv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every change of core_data_o must match the next queued load
  always @(posedge clk) begin
    #1;
    if (n_rst) begin
      if (bus.core_en_o) en_count++;
      if (bus.core_data_o !== prev_data) begin
        data_changes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_load: got %0h, expected no change", bus.core_data_o);
        end else begin
          check("load_data", bus.core_data_o, exp_q.pop_front());
        end
      end
    end
    prev_data = bus.core_data_o;
  end

  initial begin
    #200us;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string name);
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (state == s) break;
    end
    check(name, state, s);
  endtask

  task automatic press_load(input logic [DW-1:0] d, input logic [DW-1:0] e);
    int start;
    int lat;
    sw = d;
    exp_q.push_back(e);
    start = data_changes;
    lat = 0;
    load_n = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (lat == 0 && data_changes != start) lat = c;
    end
    check("load_latency", lat, 18);
    check("load_once", data_changes - start, 1);
    load_n = 1'b1;
    cycles(25);
  endtask

  task automatic clean_step();
    int start;
    start = en_count;
    step_n = 1'b0;
    cycles(30);
    step_n = 1'b1;
    cycles(25);
    check("step_pulse_count", en_count - start, 1);
  endtask

  initial begin
    int start;
    int last;
    int gaps;
    logic saw_step;

    n_rst = 1'b0; run_mode = 1'b0; step_n = 1'b1; load_n = 1'b1; sw = '0;
    bus.core_data_i = '0; bus.core_addr_i = '0;
`ifdef STEP_CTRL_BKPT_EN
    bus.bkpt_addr_i = 2'd2;
`endif
    lv[0] = '{sw: 8'h5A, exp_data: 8'h5A};
    lv[1] = '{sw: 8'hA5, exp_data: 8'hA5};
    lv[2] = '{sw: 8'hFF, exp_data: 8'hFF};
    lv[3] = '{sw: 8'h01, exp_data: 8'h01};

    #22;
    check("rst_core_en", bus.core_en_o, 0);
    check("rst_core_data", bus.core_data_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_valid", bus.result_valid_o, 0);
    check("rst_state", state, 2'b00);
    @(negedge clk);
    n_rst = 1'b1;
    cycles(3);

    // Table-driven loads
    for (int i = 0; i < 4; i++) press_load(lv[i].sw, lv[i].exp_data);

    // Bouncing step key then held: a single event
    start = en_count;
    saw_step = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step_n = (t % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (state == 2'b10) saw_step = 1'b1;
      end
    end
    step_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (state == 2'b10) saw_step = 1'b1;
      if (bus.core_en_o) check("en_in_step", state, 2'b10);
    end
    check("bounce_pulses", en_count - start, 1);
    check("bounce_saw_step", saw_step, 1);
    check("bounce_back_halt", state, 2'b00);
    step_n = 1'b1;
    cycles(25);
    check("release_no_event", en_count - start, 1);

    // Load and step together: enabled cycle sees new data
    sw = 8'h3C;
    exp_q.push_back(8'h3C);
    start = en_count;
    load_n = 1'b0; step_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.core_en_o) check("load_step_data", bus.core_data_o, 8'h3C);
    end
    check("load_step_pulses", en_count - start, 1);
    load_n = 1'b1; step_n = 1'b1;
    cycles(25);

    // Result capture at RESULT_ADDR, none elsewhere, load clears valid
    bus.core_addr_i = 2'd3; bus.core_data_i = 8'hC3;
    clean_step();
    check("capture_result", bus.result_o, 8'hC3);
    check("capture_valid", bus.result_valid_o, 1);
    bus.core_addr_i = 2'd1; bus.core_data_i = 8'h11;
    clean_step();
    check("nocapture_result", bus.result_o, 8'hC3);
    check("nocapture_valid", bus.result_valid_o, 1);
    press_load(8'h77, 8'h77);
    check("load_clears_valid", bus.result_valid_o, 0);
    check("load_keeps_result", bus.result_o, 8'hC3);

    // Free-run: one enable every 8 cycles, stops after run drops
    run_mode = 1'b1;
    wait_state(2'b01, 10, "run_enter");
    last = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.core_en_o) begin last = 1; break; end
    end
    check("run_first_tick", last, 1);
    start = en_count;
    last = 0;
    gaps = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (bus.core_en_o) begin
        gaps++;
        check("run_tick_gap", c - last, 8);
        last = c;
      end
    end
    check("run_tick_count", en_count - start, 4);
    check("run_state", state, 2'b01);
    run_mode = 1'b0;
    cycles(3);
    check("run_stop_state", state, 2'b00);
    start = en_count;
    cycles(20);
    check("run_stop_no_tick", en_count - start, 0);

`ifdef STEP_CTRL_BKPT_EN
    // Breakpoint halts with run still set; run must cycle low to resume
    bus.core_addr_i = 2'd2;
    run_mode = 1'b1;
    wait_state(2'b01, 10, "bkpt_run_enter");
    wait_state(2'b00, 20, "bkpt_halt");
    cycles(10);
    check("bkpt_stays_halt", state, 2'b00);
    run_mode = 1'b0;
    cycles(5);
    run_mode = 1'b1;
    wait_state(2'b01, 10, "bkpt_resume");
    run_mode = 1'b0;
    cycles(5);
    bus.core_addr_i = 2'd1;
`endif

    // Asynchronous reset mid-run
    run_mode = 1'b1;
    wait_state(2'b01, 10, "pre_reset_run");
    cycles(5);
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_core_en", bus.core_en_o, 0);
    check("mid_rst_core_data", bus.core_data_o, 0);
    check("mid_rst_result", bus.result_o, 0);
    check("mid_rst_valid", bus.result_valid_o, 0);
    check("mid_rst_state", state, 2'b00);
    run_mode = 1'b0;
    cycles(3);
    n_rst = 1'b1;
    cycles(5);
    check("post_rst_state", state, 2'b00);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
